// File: rtl/seed_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : seed_sweep_ctrl_if
//  Purpose  : Result channel of the seed sweep controller. One result per seed
//             is offered with a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
interface seed_sweep_ctrl_if #(
   parameter int RULES   = 32,
   parameter int SEED_AW = 10
);
   logic               res_valid;
   logic               res_ready;
   logic [SEED_AW-1:0] res_idx;
   logic [RULES-1:0]   res_state;
   logic               res_steady;
   logic               res_timeout;

   // The controller produces results.
   modport master (
      output res_valid, res_idx, res_state, res_steady, res_timeout,
      input  res_ready
   );

   // The consumer accepts results.
   modport slave (
      input  res_valid, res_idx, res_state, res_steady, res_timeout,
      output res_ready
   );
endinterface
`default_nettype wire

// File: rtl/seed_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seed_sweep_ctrl
//  Purpose  : Sweeps NUM_SEEDS seeds through a rule-network datapath. For each
//             seed: fetch from memory, reset the datapath, load the inhibitor,
//             start it, wait for the iteration limit (or a cycle timeout) and
//             report the final network state on the result channel.
//  Revision : 1.0 - initial release
// ============================================================================
module seed_sweep_ctrl #(
   parameter int RULES            = 32,
   parameter int LOG_RULES        = 5,
   parameter int LOG_ITER         = 10,
   parameter int ITERATION_NUMBER = 100,
   parameter int NUM_SEEDS        = 16,
   parameter int INHIBITOR        = 0,
   parameter int SEED_AW          = 10,
   parameter int TIMEOUT          = 4096
) (
   input  wire                  clk,
   input  wire                  rst,
   input  wire                  go,
   output logic                 busy,
   output logic                 done,
   output logic                 seed_rd,
   output logic [SEED_AW-1:0]   seed_addr,
   input  wire  [63:0]          seed_data,
   output logic                 dp_rst,
   output logic                 dp_ld_inhibitor,
   output logic                 dp_start,
   output logic [LOG_RULES-1:0] dp_sel_inhibitor,
   output logic [63:0]          dp_seed,
   input  wire  [RULES-1:0]     dp_network_state,
   input  wire                  dp_steady_state,
   input  wire  [LOG_ITER-1:0]  dp_iteration_number,
   seed_sweep_ctrl_if.master    res
);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_LATCH  = 4'd2,
      S_DPRST  = 4'd3,
      S_LOAD   = 4'd4,
      S_GAP    = 4'd5,
      S_START  = 4'd6,
      S_RUN    = 4'd7,
      S_REPORT = 4'd8
   } state_t;

   localparam logic [31:0]          c_inh_word = INHIBITOR;
   localparam logic [LOG_RULES-1:0] c_sel      = ~c_inh_word[LOG_RULES-1:0];
   localparam logic [LOG_ITER-1:0]  c_iter_lim = LOG_ITER'(ITERATION_NUMBER);
   localparam logic [15:0]          c_to_lim   = 16'(TIMEOUT - 1);
   localparam logic [SEED_AW-1:0]   c_last_idx = SEED_AW'(NUM_SEEDS - 1);
   localparam logic [SEED_AW-1:0]   c_idx_one  = 1;

   state_t               r_state;
   state_t               w_state_next;
   logic [SEED_AW-1:0]   r_index;
   logic [15:0]          r_run_cnt;
   logic                 r_rst_phase;

   logic                 w_iter_done;
   logic                 w_timeout;
   logic                 w_run_exit;
   logic                 w_handshake;
   logic                 w_more;
   logic [SEED_AW-1:0]   w_index_inc;

   // The inhibitor select is a constant tie-off, valid even in reset.
   assign dp_sel_inhibitor = c_sel;

   assign w_iter_done = (dp_iteration_number >= c_iter_lim);
   assign w_timeout   = (r_run_cnt == c_to_lim);
   assign w_run_exit  = w_iter_done || w_timeout;
   assign w_handshake = res.res_valid && res.res_ready;
   assign w_more      = (r_index < c_last_idx);
   assign w_index_inc = r_index + c_idx_one;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode; DPRST lasts two cycles, tracked by r_rst_phase.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:   if (go) w_state_next = S_FETCH;
         S_FETCH:  w_state_next = S_LATCH;
         S_LATCH:  w_state_next = S_DPRST;
         S_DPRST:  if (r_rst_phase) w_state_next = S_LOAD;
         S_LOAD:   w_state_next = S_GAP;
         S_GAP:    w_state_next = S_START;
         S_START:  w_state_next = S_RUN;
         S_RUN:    if (w_run_exit) w_state_next = S_REPORT;
         S_REPORT: if (w_handshake) w_state_next = w_more ? S_FETCH : S_IDLE;
         default:  w_state_next = S_IDLE;
      endcase
   end

   // Registered outputs, seed index, run counter and result capture.
   // ld_inhibitor and start are registered copies of LOAD and START, so they
   // appear one cycle after those states (3 and 5 cycles after dp_rst falls).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy            <= 1'b0;
         done            <= 1'b0;
         seed_rd         <= 1'b0;
         seed_addr       <= '0;
         dp_rst          <= 1'b0;
         dp_ld_inhibitor <= 1'b0;
         dp_start        <= 1'b0;
         dp_seed         <= '0;
         r_index         <= '0;
         r_rst_phase     <= 1'b0;
         r_run_cnt       <= '0;
         res.res_valid   <= 1'b0;
         res.res_idx     <= '0;
         res.res_state   <= '0;
         res.res_steady  <= 1'b0;
         res.res_timeout <= 1'b0;
      end else begin
         done            <= 1'b0;
         seed_rd         <= 1'b0;
         dp_ld_inhibitor <= (r_state == S_LOAD);
         dp_start        <= (r_state == S_START);
         case (r_state)
            S_IDLE: begin
               if (go) begin
                  busy      <= 1'b1;
                  r_index   <= '0;
                  seed_rd   <= 1'b1;
                  seed_addr <= '0;
               end
            end
            S_LATCH: begin
               dp_seed     <= seed_data;
               dp_rst      <= 1'b0;
               r_rst_phase <= 1'b0;
            end
            S_DPRST: begin
               r_rst_phase <= 1'b1;
               if (r_rst_phase) dp_rst <= 1'b1;
            end
            S_START: begin
               r_run_cnt <= '0;
            end
            S_RUN: begin
               r_run_cnt <= r_run_cnt + 16'd1;
               if (w_run_exit) begin
                  res.res_valid   <= 1'b1;
                  res.res_idx     <= r_index;
                  res.res_state   <= dp_network_state;
                  res.res_steady  <= dp_steady_state;
                  // Reaching the iteration limit wins over a coincident timeout.
                  res.res_timeout <= ~w_iter_done;
               end
            end
            S_REPORT: begin
               if (w_handshake) begin
                  res.res_valid <= 1'b0;
                  if (w_more) begin
                     r_index   <= w_index_inc;
                     seed_rd   <= 1'b1;
                     seed_addr <= w_index_inc;
                  end else begin
                     busy <= 1'b0;
                     done <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seed_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seed_sweep_ctrl
//  Purpose  : Scoreboard bench for seed_sweep_ctrl with a seed memory model
//             and a counting datapath model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seed_sweep_ctrl;

   localparam int RULES     = 32;
   localparam int LOG_RULES = 5;
   localparam int LOG_ITER  = 10;
   localparam int ITER_N    = 4;
   localparam int NSEEDS    = 3;
   localparam int SEED_AW   = 10;
   localparam int TMO       = 8;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 go;
   logic                 busy, done, seed_rd;
   logic [SEED_AW-1:0]   seed_addr;
   logic [63:0]          seed_data = '0;
   logic                 dp_rst, dp_ld_inhibitor, dp_start;
   logic [LOG_RULES-1:0] dp_sel_inhibitor;
   logic [63:0]          dp_seed;
   logic [RULES-1:0]     dp_network_state;
   logic                 dp_steady_state;
   logic [LOG_ITER-1:0]  dp_iteration_number;

   seed_sweep_ctrl_if #(.RULES(RULES), .SEED_AW(SEED_AW)) res_if ();

   seed_sweep_ctrl #(
      .RULES(RULES), .LOG_RULES(LOG_RULES), .LOG_ITER(LOG_ITER),
      .ITERATION_NUMBER(ITER_N), .NUM_SEEDS(NSEEDS), .INHIBITOR(0),
      .SEED_AW(SEED_AW), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst(rst), .go(go), .busy(busy), .done(done),
      .seed_rd(seed_rd), .seed_addr(seed_addr), .seed_data(seed_data),
      .dp_rst(dp_rst), .dp_ld_inhibitor(dp_ld_inhibitor), .dp_start(dp_start),
      .dp_sel_inhibitor(dp_sel_inhibitor), .dp_seed(dp_seed),
      .dp_network_state(dp_network_state), .dp_steady_state(dp_steady_state),
      .dp_iteration_number(dp_iteration_number), .res(res_if)
   );

   always #5 clk = ~clk;

   // ---------------- models ----------------
   logic [63:0]         mem [0:NSEEDS-1];
   logic [LOG_ITER-1:0] iter = '0;
   logic                running = 1'b0;
   logic                stuck;
   int                  cyc = 0;

   // Seed memory: data one cycle after the read strobe.
   always @(posedge clk) begin
      if (seed_rd) seed_data <= (int'(seed_addr) < NSEEDS) ? mem[seed_addr] : 64'h0;
   end

   // Datapath: clears while dp_rst is low, counts one per cycle after dp_start.
   always @(posedge clk) begin
      if (!dp_rst) begin
         iter    <= '0;
         running <= 1'b0;
      end else if (dp_start || running) begin
         running <= 1'b1;
         if (!stuck) iter <= iter + 1'b1;
      end
   end

   assign dp_iteration_number = iter;
   assign dp_network_state    = dp_seed[31:0] ^ {22'd0, iter};
   assign dp_steady_state     = (iter >= 10'd3);

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [SEED_AW-1:0] idx;
      logic [RULES-1:0]   state;
      logic               steady;
      logic               tmo;
      logic [63:0]        seed;
      int                 lat;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   results_seen = 0;
   int   done_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected results of a full sweep; iter is 4 at a normal exit and
   // stuck at 0 for a timeout exit (dp_start to res_valid: 5 vs 8 cycles).
   task automatic push_sweep(input bit tmo_mode);
      exp_t        e;
      logic [63:0] s;
      for (int i = 0; i < NSEEDS; i++) begin
         s        = mem[i];
         e.idx    = SEED_AW'(i);
         e.seed   = s;
         e.state  = s[31:0] ^ (tmo_mode ? 32'd0 : 32'd4);
         e.steady = !tmo_mode;
         e.tmo    = tmo_mode;
         e.lat    = tmo_mode ? 8 : 5;
         q.push_back(e);
      end
   endtask

   // Monitor: result checks, stall stability and pulse timing.
   initial begin : monitor
      exp_t               e;
      logic               prev_valid, prev_dp_rst, armed;
      int                 t0, start_cyc, rise_cyc;
      logic [SEED_AW-1:0] h_idx;
      logic [RULES-1:0]   h_state;
      logic               h_steady, h_tmo;
      prev_valid = 0; prev_dp_rst = 0; armed = 0;
      t0 = 0; start_cyc = 0; rise_cyc = 0;
      h_idx = '0; h_state = '0; h_steady = 0; h_tmo = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev_valid = 0; prev_dp_rst = 0; armed = 0;
         end else begin
            if (prev_dp_rst && !dp_rst) begin
               t0 = cyc; armed = 1;
            end
            if (armed && !prev_dp_rst && dp_rst) chk("dp_rst_low_cycles", 64'(cyc - t0), 64'd2);
            if (armed && dp_ld_inhibitor) chk("ld_inhibitor_offset", 64'(cyc - t0), 64'd3);
            if (armed && dp_start) begin
               chk("dp_start_offset", 64'(cyc - t0), 64'd5);
               armed = 0;
            end
            if (dp_start) start_cyc = cyc;
            if (done) done_cnt++;
            if (res_if.res_valid && !prev_valid) begin
               rise_cyc = cyc;
               h_idx = res_if.res_idx; h_state = res_if.res_state;
               h_steady = res_if.res_steady; h_tmo = res_if.res_timeout;
            end else if (res_if.res_valid && prev_valid) begin
               chk("stall_idx_stable",    64'(res_if.res_idx),     64'(h_idx));
               chk("stall_state_stable",  64'(res_if.res_state),   64'(h_state));
               chk("stall_steady_stable", 64'(res_if.res_steady),  64'(h_steady));
               chk("stall_tmo_stable",    64'(res_if.res_timeout), 64'(h_tmo));
            end
            if (res_if.res_valid && !res_if.res_ready) chk("no_seed_rd_in_stall", 64'(seed_rd), 64'd0);
            if (res_if.res_valid && res_if.res_ready) begin
               results_seen++;
               if (q.size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL unexpected_result: idx %0d arrived, none expected", res_if.res_idx);
               end else begin
                  e = q.pop_front();
                  chk("res_idx",     64'(res_if.res_idx),     64'(e.idx));
                  chk("res_state",   64'(res_if.res_state),   64'(e.state));
                  chk("res_steady",  64'(res_if.res_steady),  64'(e.steady));
                  chk("res_timeout", 64'(res_if.res_timeout), 64'(e.tmo));
                  chk("dp_seed",     dp_seed,                 e.seed);
                  chk("run_latency", 64'(rise_cyc - start_cyc), 64'(e.lat));
               end
            end
            prev_valid  = res_if.res_valid;
            prev_dp_rst = dp_rst;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_go();
      go = 1'b1;
      tick(1);
      go = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin
         tick(1);
         n++;
      end
      chk("done_seen", 64'(done), 64'd1);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_busy"},    64'(busy), 64'd0);
      chk({tag, "_done"},    64'(done), 64'd0);
      chk({tag, "_seed_rd"}, 64'(seed_rd), 64'd0);
      chk({tag, "_addr"},    64'(seed_addr), 64'd0);
      chk({tag, "_dp_rst"},  64'(dp_rst), 64'd0);
      chk({tag, "_ld"},      64'(dp_ld_inhibitor), 64'd0);
      chk({tag, "_start"},   64'(dp_start), 64'd0);
      chk({tag, "_dp_seed"}, dp_seed, 64'd0);
      chk({tag, "_valid"},   64'(res_if.res_valid), 64'd0);
      chk({tag, "_idx"},     64'(res_if.res_idx), 64'd0);
      chk({tag, "_state"},   64'(res_if.res_state), 64'd0);
      chk({tag, "_steady"},  64'(res_if.res_steady), 64'd0);
      chk({tag, "_tmo"},     64'(res_if.res_timeout), 64'd0);
      chk({tag, "_sel"},     64'(dp_sel_inhibitor), 64'h1F);
   endtask

   initial begin : stim
      int n;
      mem[0] = 64'h0123_4567_89AB_CDEF;
      mem[1] = 64'hDEAD_BEEF_CAFE_F00D;
      mem[2] = 64'h1357_9BDF_2468_ACE0;
      rst = 1'b0; go = 1'b0; stuck = 1'b0;
      res_if.res_ready = 1'b1;
      tick(3);
      check_reset_values("reset");
      rst = 1'b1;
      tick(2);
      chk("idle_dp_rst_low", 64'(dp_rst), 64'd0);
      chk("idle_busy",       64'(busy), 64'd0);

      // Nominal sweep with a spurious go while busy.
      results_seen = 0; done_cnt = 0;
      push_sweep(1'b0);
      pulse_go();
      chk("busy_after_go", 64'(busy), 64'd1);
      tick(12);
      chk("busy_mid_sweep", 64'(busy), 64'd1);
      pulse_go();
      wait_done(1000);
      tick(10);
      chk("nominal_results", 64'(results_seen), 64'd3);
      chk("nominal_done_cnt", 64'(done_cnt), 64'd1);
      chk("nominal_queue_empty", 64'(q.size()), 64'd0);
      chk("nominal_idle_busy", 64'(busy), 64'd0);
      chk("nominal_final_dp_rst", 64'(dp_rst), 64'd1);

      // Timeout sweep with 5 cycles of backpressure on the first result.
      results_seen = 0; done_cnt = 0;
      stuck = 1'b1;
      res_if.res_ready = 1'b0;
      push_sweep(1'b1);
      pulse_go();
      n = 0;
      while (res_if.res_valid !== 1'b1 && n < 500) begin tick(1); n++; end
      chk("valid_before_stall", 64'(res_if.res_valid), 64'd1);
      tick(5);
      chk("valid_held_after_stall", 64'(res_if.res_valid), 64'd1);
      res_if.res_ready = 1'b1;
      wait_done(1000);
      tick(5);
      chk("timeout_results", 64'(results_seen), 64'd3);
      chk("timeout_done_cnt", 64'(done_cnt), 64'd1);
      stuck = 1'b0;

      // Mid-run reset during seed 1, then a clean restart.
      results_seen = 0; done_cnt = 0;
      push_sweep(1'b0);
      pulse_go();
      n = 0;
      while (results_seen < 1 && n < 500) begin tick(1); n++; end
      chk("first_result_before_reset", 64'(results_seen), 64'd1);
      n = 0;
      while (dp_start !== 1'b1 && n < 500) begin tick(1); n++; end
      chk("seed1_started", 64'(dp_start), 64'd1);
      tick(2);
      #2;
      rst = 1'b0;
      #1;
      check_reset_values("midrun");
      q.delete();
      tick(1);
      rst = 1'b1;
      tick(1);
      results_seen = 0; done_cnt = 0;
      push_sweep(1'b0);
      pulse_go();
      wait_done(1000);
      tick(5);
      chk("restart_results", 64'(results_seen), 64'd3);
      chk("restart_done_cnt", 64'(done_cnt), 64'd1);
      chk("restart_queue_empty", 64'(q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Hard stop in case the stimulus ever wedges.
   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire
